// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared constants, FSM state type and saturating shift for the CSR SpMV engine
package spmv_pkg;

   localparam int DW_DEF      = 16;
   localparam int FRAC_DEF    = 8;
   localparam int NNZ_MAX_DEF = 1024;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_BASE,
      S_SETUP,
      S_MAC,
      S_DRAIN1,
      S_DRAIN2,
      S_WRITE,
      S_FETCH,
      S_DONE
   } state_t;

   // Accumulator is wide enough to sum NNZ_MAX full-precision products without overflow.
   function automatic int acc_width(input int dw, input int nnz_max);
      return 2 * dw + $clog2(nnz_max);
   endfunction

   localparam int ACC_W_DEF = 2 * DW_DEF + $clog2(NNZ_MAX_DEF);

   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] a,
                                                    input int frac, input int dw);
      logic signed [63:0] s, hi, lo;
      s  = a >>> frac;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      return s;
   endfunction

endpackage

// File: rtl/spmv_mac.sv
// rtl/spmv_mac.sv - two-stage multiply-accumulate with clear and saturated Q-format output
module spmv_mac
   import spmv_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int FRAC = FRAC_DEF,
   parameter int AW   = ACC_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 issue,
   input  logic signed [DW-1:0] val_in,
   input  logic signed [DW-1:0] x_in,
   output logic                 stage1,
   output logic [DW-1:0]        y_sat
);

   logic                   stage2;
   logic signed [DW-1:0]   val_q;
   logic signed [AW-1:0]   acc;
   logic signed [2*DW-1:0] prod;

   assign prod  = (2*DW)'(val_q) * (2*DW)'(x_in);
   assign y_sat = DW'(sat_shift(64'(acc), FRAC, DW));

   // stage1: val/col arrive from memory; stage2: matching x arrives and is accumulated.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage1 <= 1'b0;
         stage2 <= 1'b0;
         val_q  <= '0;
         acc    <= '0;
      end else begin
         stage1 <= issue;
         stage2 <= stage1;
         if (stage1)
            val_q <= val_in;
         if (clear)
            acc <= '0;
         else if (stage2)
            acc <= acc + AW'(prod);
      end
   end

endmodule

// File: rtl/csr_spmv_engine.sv
// rtl/csr_spmv_engine.sv - CSR sparse matrix-vector multiplier, one nonzero per cycle, row-by-row writeback
module csr_spmv_engine
   import spmv_pkg::*;
#(
   parameter int N       = 100,
   parameter int NNZ_MAX = NNZ_MAX_DEF,
   parameter int DW      = DW_DEF,
   parameter int FRAC    = FRAC_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [$clog2(N+1)-1:0]       rp_addr,
   input  logic [$clog2(NNZ_MAX+1)-1:0] rp_data,
   output logic [$clog2(NNZ_MAX)-1:0]   nz_addr,
   input  logic [DW-1:0]                nz_val,
   input  logic [$clog2(N)-1:0]         nz_col,
   output logic [$clog2(N)-1:0]         x_addr,
   input  logic [DW-1:0]                x_data,
   output logic                         y_we,
   output logic [$clog2(N)-1:0]         y_addr,
   output logic [DW-1:0]                y_data
);

   localparam int RPW = $clog2(N + 1);
   localparam int KW  = $clog2(NNZ_MAX + 1);
   localparam int CW  = $clog2(N);
   localparam int NZA = $clog2(NNZ_MAX);
   localparam int AW  = acc_width(DW, NNZ_MAX);

   state_t          state, state_n;
   logic [KW-1:0]   k, row_end;
   logic [CW-1:0]   r;
   logic            bad_row, row_empty, issue, clear, stage1;
   logic [DW-1:0]   y_sat;

   // A row end behind the current pointer or past the memory is flagged and written as zero.
   assign bad_row   = (rp_data < k) || (rp_data > KW'(NNZ_MAX));
   assign row_empty = bad_row || (rp_data == k);
   assign x_addr    = stage1 ? nz_col : '0;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   spmv_mac #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .issue  (issue),
      .val_in (nz_val),
      .x_in   (x_data),
      .stage1 (stage1),
      .y_sat  (y_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         k       <= '0;
         row_end <= '0;
         r       <= '0;
         err     <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            S_IDLE:  if (start) begin
                        err <= 1'b0;
                        r   <= '0;
                     end
            S_BASE:  k <= rp_data;
            S_SETUP: begin
                        row_end <= rp_data;
                        if (bad_row)
                           err <= 1'b1;
                     end
            S_MAC:   k <= k + KW'(1);
            S_WRITE: r <= r + CW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      rp_addr = '0;
      nz_addr = '0;
      issue   = 1'b0;
      clear   = 1'b0;
      y_we    = 1'b0;
      y_addr  = '0;
      y_data  = '0;
      case (state)
         S_IDLE:   if (start) state_n = S_INIT;
         S_INIT:   state_n = S_BASE;
         S_BASE:   begin
                      rp_addr = RPW'(1);
                      state_n = S_SETUP;
                   end
         S_SETUP:  begin
                      clear   = 1'b1;
                      state_n = row_empty ? S_WRITE : S_MAC;
                   end
         S_MAC:    begin
                      nz_addr = NZA'(k);
                      issue   = 1'b1;
                      if (k + KW'(1) == row_end)
                         state_n = S_DRAIN1;
                   end
         S_DRAIN1: state_n = S_DRAIN2;
         S_DRAIN2: state_n = S_WRITE;
         S_WRITE:  begin
                      y_we    = 1'b1;
                      y_addr  = r;
                      y_data  = y_sat;
                      state_n = (r == CW'(N - 1)) ? S_DONE : S_FETCH;
                   end
         S_FETCH:  begin
                      rp_addr = RPW'(r) + RPW'(1);
                      state_n = S_SETUP;
                   end
         S_DONE:   state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_spmv_engine.sv
// tb/tb_csr_spmv_engine.sv - scoreboard bench for csr_spmv_engine with synchronous memory models
module tb_csr_spmv_engine;

   localparam int N       = 100;
   localparam int NNZ_MAX = 1024;
   localparam int DW      = 16;
   localparam int FRAC    = 8;
   localparam int RPW     = $clog2(N + 1);
   localparam int KW      = $clog2(NNZ_MAX + 1);
   localparam int NZA     = $clog2(NNZ_MAX);
   localparam int CW      = $clog2(N);

   logic           clk = 1'b0;
   logic           rst, start;
   logic           busy, done, err, y_we;
   logic [RPW-1:0] rp_addr;
   logic [KW-1:0]  rp_data;
   logic [NZA-1:0] nz_addr;
   logic [DW-1:0]  nz_val, x_data, y_data;
   logic [CW-1:0]  nz_col, x_addr, y_addr;

   int             rp_mem [0:N];
   logic [DW-1:0]  val_mem[0:NNZ_MAX-1];
   logic [CW-1:0]  col_mem[0:NNZ_MAX-1];
   logic [DW-1:0]  x_mem  [0:N-1];

   typedef struct {
      int row;
      int data;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   exp_done;
   bit   exp_err;
   int   q[$];

   csr_spmv_engine #(.N(N), .NNZ_MAX(NNZ_MAX), .DW(DW), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .rp_addr(rp_addr), .rp_data(rp_data), .nz_addr(nz_addr), .nz_val(nz_val),
      .nz_col(nz_col), .x_addr(x_addr), .x_data(x_data), .y_we(y_we),
      .y_addr(y_addr), .y_data(y_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rp_data <= KW'(rp_mem[rp_addr]);
      nz_val  <= val_mem[nz_addr];
      nz_col  <= col_mem[nz_addr];
      x_data  <= x_mem[x_addr];
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void load_rp(input int p[$]);
      for (int i = 0; i <= N; i++)
         rp_mem[i] = (i < p.size()) ? p[i] : p[p.size()-1];
   endfunction

   // Reference: walk rowPtr, accumulate exactly, floor-shift, clamp; also predict write cycles.
   function automatic void build_expected();
      int     k, t, re, nnz;
      longint acc, s;
      sbq.delete();
      k = rp_mem[0];
      t = 2;
      exp_err = 1'b0;
      for (int r = 0; r < N; r++) begin
         re  = rp_mem[r+1];
         nnz = 0;
         acc = 0;
         if (re < k || re > NNZ_MAX)
            exp_err = 1'b1;
         else begin
            for (int j = k; j < re; j++)
               acc += longint'($signed(val_mem[j])) * longint'($signed(x_mem[col_mem[j]]));
            nnz = re - k;
            k   = re;
         end
         t += (nnz == 0) ? ((r == 0) ? 2 : 3) : (nnz + ((r == 0) ? 4 : 5));
         s = acc >>> FRAC;
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
         sbq.push_back('{r, int'(s) & 32'hFFFF, t});
      end
      exp_done = t + 1;
   endfunction

   task automatic run_op(input int budget);
      int   c0, rel;
      bit   got_done;
      exp_t e;
      build_expected();
      @(posedge clk); #1 start = 1'b1; c0 = cyc;
      @(posedge clk); #1 start = 1'b0;
      got_done = 1'b0;
      for (int n = 0; n < budget && !got_done; n++) begin
         @(negedge clk);
         rel = cyc - c0;
         if (rel == 1) begin
            check_val("busy_after_start", 64'(busy), 64'd1);
            check_val("err_cleared", 64'(err), 64'd0);
         end
         if (y_we) begin
            if (sbq.size() == 0)
               check_val("extra_write", 64'd1, 64'd0);
            else begin
               e = sbq.pop_front();
               check_val("y_addr", 64'(y_addr), 64'(e.row));
               check_val("y_data", 64'(y_data), 64'(e.data));
               check_val("y_cycle", 64'(rel), 64'(e.cyc));
            end
         end
         if (done) begin
            got_done = 1'b1;
            check_val("done_cycle", 64'(rel), 64'(exp_done));
            check_val("err_final", 64'(err), 64'(exp_err));
            check_val("rows_pending", 64'(sbq.size()), 64'd0);
         end
      end
      if (!got_done)
         check_val("done_timeout", 64'd0, 64'd1);
      @(negedge clk);
      check_val("busy_idle", 64'(busy), 64'd0);
      check_val("done_pulse", 64'(done), 64'd0);
   endtask

   initial begin
      int  total;
      bit  saw_we, hit;
      for (int i = 0; i < NNZ_MAX; i++) begin
         val_mem[i] = '0;
         col_mem[i] = '0;
      end
      for (int i = 0; i < N; i++)
         x_mem[i] = '0;
      q = '{0};
      load_rp(q);
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_err", 64'(err), 64'd0);
      check_val("rst_y_we", 64'(y_we), 64'd0);
      check_val("rst_addrs", 64'({rp_addr, nz_addr, x_addr, y_addr}), 64'd0);
      check_val("rst_y_data", 64'(y_data), 64'd0);
      #1 rst = 1'b0;

      // Basic two-row example, remaining rows empty.
      q = '{0, 2, 3};
      load_rp(q);
      val_mem[0] = 16'h0100; val_mem[1] = 16'h0200; val_mem[2] = 16'h0300;
      col_mem[0] = 0; col_mem[1] = 1; col_mem[2] = 1;
      x_mem[0] = 16'h0100; x_mem[1] = 16'h0080;
      run_op(2000);

      // Empty middle row.
      q = '{0, 1, 1, 2};
      load_rp(q);
      run_op(2000);

      // Positive and negative saturation.
      q = '{0, 1, 2};
      load_rp(q);
      val_mem[0] = 16'h7F00; val_mem[1] = 16'h8100;
      col_mem[0] = 0; col_mem[1] = 0;
      x_mem[0] = 16'h7F00;
      run_op(2000);

      // Malformed rowPtr; the following run checks err is cleared again.
      q = '{0, 3, 1, 3};
      load_rp(q);
      run_op(2000);
      run_op(2000);

      // Reset during MAC of row 1.
      q = '{0, 2, 5};
      load_rp(q);
      for (int i = 0; i < 5; i++) begin
         val_mem[i] = DW'(16'h0040 * (i + 1));
         col_mem[i] = CW'(i);
         x_mem[i]   = DW'(16'h0100 - 16'h0020 * i);
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
         @(negedge clk);
         if (y_we && y_addr == 0) hit = 1'b1;
      end
      check_val("row0_write_seen", 64'(hit), 64'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_val("busy_after_rst", 64'(busy), 64'd0);
      saw_we = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (y_we) saw_we = 1'b1;
      end
      check_val("no_we_after_rst", 64'(saw_we), 64'd0);
      run_op(2000);

      // Random 100x100 Q8.8 matrix, ~10% density.
      total = 0;
      rp_mem[0] = 0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 9) == 0 && total < NNZ_MAX) begin
               col_mem[total] = CW'(c);
               val_mem[total] = DW'($urandom_range(0, 1023) - 512);
               total++;
            end
         end
         rp_mem[r+1] = total;
      end
      for (int i = 0; i < N; i++)
         x_mem[i] = DW'($urandom_range(0, 1023) - 512);
      run_op(5000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
